// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: standard IV, controller state encoding and the
// rotate/sigma helpers used by the message schedule.
package sha256_pkg;

    localparam logic [255:0] SHA256_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FINAL,
        ST_DONE
    } round_state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word message schedule ring; w_out is W[t] for the current round and each
// shift appends W[t+16] while retiring W[t].
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output logic [31:0]  w_out
);

    logic [31:0] ring [16];
    logic [31:0] w_next;

    // ring[k] holds W[t+k], so the recurrence taps are offsets 14, 9, 1 and 0
    always_comb begin
        w_next = sig1(ring[14]) + ring[9] + sig0(ring[1]) + ring[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) ring[i] <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++) ring[i] <= block_in[511 - 32*i -: 32];
        end else if (shift) begin
            for (int unsigned i = 0; i < 15; i++) ring[i] <= ring[i+1];
            ring[15] <= w_next;
        end
    end

    assign w_out = ring[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression controller: sequences 64 rounds through an external
// round datapath of DP_LATENCY cycles and forms the final digest.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned DP_LATENCY = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    input  logic         use_iv,
    output logic [31:0]  dp_a,
    output logic [31:0]  dp_b,
    output logic [31:0]  dp_c,
    output logic [31:0]  dp_d,
    output logic [31:0]  dp_e,
    output logic [31:0]  dp_f,
    output logic [31:0]  dp_g,
    output logic [31:0]  dp_h,
    output logic [31:0]  dp_w,
    output logic [5:0]   dp_select,
    input  logic [31:0]  dp_new_a,
    input  logic [31:0]  dp_new_e,
    output logic [255:0] digest,
    output logic         done
);

    localparam logic [1:0] LAT_LAST = 2'(DP_LATENCY - 1);

    round_state_t state, state_nxt;
    logic [31:0]  wv    [8];
    logic [31:0]  chain [8];
    logic [5:0]   round_cnt;
    logic [1:0]   lat_cnt;
    logic         accept, capture;
    logic [255:0] init_hash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = (round_cnt == 6'd63) ? ST_FINAL : ST_ISSUE;
                end
            end
            ST_FINAL: state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign init_hash = use_iv ? SHA256_IV : hash_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
            lat_cnt   <= '0;
        end else if (accept) begin
            round_cnt <= '0;
            lat_cnt   <= '0;
        end else if (state == ST_WAIT) begin
            lat_cnt <= capture ? 2'd0 : lat_cnt + 2'd1;
            if (capture) round_cnt <= round_cnt + 6'd1;
        end
    end

    // wv[0..7] = a..h; capture shifts both halves and inserts the new a and e
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                wv[i]    <= '0;
                chain[i] <= '0;
            end
        end else if (accept) begin
            for (int unsigned i = 0; i < 8; i++) begin
                wv[i]    <= init_hash[255 - 32*i -: 32];
                chain[i] <= init_hash[255 - 32*i -: 32];
            end
        end else if (capture) begin
            wv[0] <= dp_new_a;
            wv[1] <= wv[0];
            wv[2] <= wv[1];
            wv[3] <= wv[2];
            wv[4] <= dp_new_e;
            wv[5] <= wv[4];
            wv[6] <= wv[5];
            wv[7] <= wv[6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digest <= '0;
        end else if (state == ST_FINAL) begin
            for (int unsigned i = 0; i < 8; i++) digest[255 - 32*i -: 32] <= chain[i] + wv[i];
        end
    end

    sha256_msg_sched u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift    (capture),
        .block_in (block_in),
        .w_out    (dp_w)
    );

    assign dp_a      = wv[0];
    assign dp_b      = wv[1];
    assign dp_c      = wv[2];
    assign dp_d      = wv[3];
    assign dp_e      = wv[4];
    assign dp_f      = wv[5];
    assign dp_g      = wv[6];
    assign dp_h      = wv[7];
    assign dp_select = round_cnt;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl at DP_LATENCY 1 and 3, each paired with
// a pipelined golden round datapath and a software compression reference.
module tb_sha256_round_ctrl;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start1, start3, use_iv;
    logic [511:0] block_in;
    logic [255:0] hash_in;

    logic         ready1, done1, ready3, done3;
    logic [31:0]  a1, b1, c1, d1, e1, f1, g1, h1, w1, na1, ne1;
    logic [31:0]  a3, b3, c3, d3, e3, f3, g3, h3, w3, na3, ne3;
    logic [5:0]   sel1, sel3;
    logic [255:0] dig1, dig3;

    sha256_round_ctrl #(.DP_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1),
        .block_in(block_in), .hash_in(hash_in), .use_iv(use_iv),
        .dp_a(a1), .dp_b(b1), .dp_c(c1), .dp_d(d1), .dp_e(e1), .dp_f(f1), .dp_g(g1), .dp_h(h1),
        .dp_w(w1), .dp_select(sel1), .dp_new_a(na1), .dp_new_e(ne1),
        .digest(dig1), .done(done1)
    );

    sha256_round_ctrl #(.DP_LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .ready(ready3),
        .block_in(block_in), .hash_in(hash_in), .use_iv(use_iv),
        .dp_a(a3), .dp_b(b3), .dp_c(c3), .dp_d(d3), .dp_e(e3), .dp_f(f3), .dp_g(g3), .dp_h(h3),
        .dp_w(w3), .dp_select(sel3), .dp_new_a(na3), .dp_new_e(ne3),
        .digest(dig3), .done(done3)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // One SHA-256 round: returns {T1+T2, d+T1}
    function automatic logic [63:0] rnd(input logic [31:0] a, b, c, d, e, f, g, h, w, input logic [5:0] t);
        logic [31:0] t1, t2;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, d + t1};
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [63:0]  r;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            r = rnd(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7], w[t], 6'(t));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = r[31:0];
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = r[63:32];
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = v[i] + hv[255 - 32*i -: 32];
        return res;
    endfunction

    // Golden datapaths: results appear DP_LATENCY cycles after the inputs are presented
    logic [63:0] pipe1;
    logic [63:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= rnd(a1, b1, c1, d1, e1, f1, g1, h1, w1, sel1);
        pipe3[0] <= rnd(a3, b3, c3, d3, e3, f3, g3, h3, w3, sel3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign {na1, ne1} = pipe1;
    assign {na3, ne3} = pipe3[2];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one block on the selected instance and follow it to the done pulse.
    // edges = rising edges from the accepting edge to the edge consuming done (-1 on timeout).
    task automatic run(input int sel, input bit hold, input int corrupt_at,
                       output int edges, output int ready_hi, output int sel_bad);
        int   lat;
        logic cur_ready, cur_done;
        logic [5:0] cur_sel;
        lat      = (sel == 3) ? 3 : 1;
        edges    = -1;
        ready_hi = 0;
        sel_bad  = 0;
        @(negedge clk);
        if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            start1 = 1'b0;
            start3 = 1'b0;
        end
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == corrupt_at) begin
                block_in = {16{32'hdeadbeef}};
                hash_in  = ~hash_in ^ 256'h1234;
                use_iv   = ~use_iv;
            end
            cur_ready = (sel == 3) ? ready3 : ready1;
            cur_done  = (sel == 3) ? done3  : done1;
            cur_sel   = (sel == 3) ? sel3   : sel1;
            if (cur_done) begin
                edges = k + 1;
                break;
            end
            if (cur_ready) ready_hi++;
            if (k < 64*(lat+1) && cur_sel != 6'(k / (lat+1))) sel_bad++;
        end
    endtask

    initial begin
        int edges, rh, sb, guard;
        logic [255:0] exp2;
        start1 = 1'b0; start3 = 1'b0; use_iv = 1'b1;
        block_in = ABC_BLK; hash_in = '0;
        rst_n = 1'b0;
        #12;
        check("rst_ready1", ready1, 1);
        check("rst_done1", done1, 0);
        check("rst_dp1", {a1, b1, c1, d1, e1, f1, g1, h1}, 0);
        check("rst_w_sel1", {w1, sel1}, 0);
        check("rst_digest1", dig1, 0);
        check("rst_ready3", ready3, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // "abc" at latency 1
        run(1, 1'b0, -1, edges, rh, sb);
        check("abc_digest", dig1, ABC_DIG);
        check("abc_edges", edges, 130);
        check("abc_ready_low", rh, 0);
        check("abc_select_seq", sb, 0);

        // empty message
        block_in = EMPTY_BLK;
        run(1, 1'b0, -1, edges, rh, sb);
        check("empty_digest", dig1, EMPTY_DIG);
        check("empty_edges", edges, 130);

        // chaining from the "abc" digest
        block_in = ABC_BLK; hash_in = ABC_DIG; use_iv = 1'b0;
        exp2 = ref_compress(ABC_DIG, ABC_BLK);
        run(1, 1'b0, -1, edges, rh, sb);
        check("chain_digest", dig1, exp2);
        check("chain_ready_low", rh, 0);
        check("chain_edges", edges, 130);
        hash_in = '0;
        repeat (4) @(negedge clk);
        check("digest_hold", dig1, exp2);
        check("idle_ready", ready1, 1);

        // latency 3
        use_iv = 1'b1; block_in = ABC_BLK;
        run(3, 1'b0, -1, edges, rh, sb);
        check("l3_digest", dig3, ABC_DIG);
        check("l3_edges", edges, 258);
        check("l3_select_seq", sb, 0);
        check("l3_ready_low", rh, 0);

        // reset at round 30
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sel1 == 6'd30) break;
        end
        check("reach_round30", sel1, 30);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", ready1, 1);
        check("midrst_done", done1, 0);
        check("midrst_dp", {a1, b1, c1, d1, e1, f1, g1, h1}, 0);
        check("midrst_w_sel", {w1, sel1}, 0);
        check("midrst_digest", dig1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 1'b0, -1, edges, rh, sb);
        check("post_rst_digest", dig1, ABC_DIG);
        check("post_rst_edges", edges, 130);

        // start held high, inputs disturbed mid-run
        block_in = ABC_BLK; use_iv = 1'b1; hash_in = 256'h5555;
        run(1, 1'b1, 40, edges, rh, sb);
        check("hold_digest", dig1, ABC_DIG);
        check("hold_ready_low", rh, 0);
        check("hold_edges", edges, 130);
        @(negedge clk);
        check("hold_idle_visit", ready1, 1);
        @(negedge clk);
        check("hold_reaccept", ready1, 0);
        start1 = 1'b0;
        exp2 = ref_compress(use_iv ? IV : hash_in, block_in);
        guard = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done1) begin
                guard = 1;
                break;
            end
        end
        check("second_done_seen", guard, 1);
        check("second_digest", dig1, exp2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_round_ctrl.md
SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

Interface
REQ-001 Parameter: DP_LATENCY, default 1, round datapath issue-to-result latency in cycles; legal range 1..4.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request to compress one block; accepted only when start && ready.
REQ-005 ready  out  1  high only in IDLE.
REQ-006 block_in  in  512  message block; word 0 = bits 511:480; sampled only on the accepting edge.
REQ-007 hash_in  in  256  chaining value; H0 = bits 255:224; sampled only on the accepting edge.
REQ-008 use_iv  in  1  sampled with start; 1 = use SHA-256 standard IV instead of hash_in.
REQ-009 dp_a..dp_h  out  32 each  working variables driven to the round datapath.
REQ-010 dp_w  out  32  message schedule word W[t] for the current round.
REQ-011 dp_select  out  6  round index t, selecting K[t] in the datapath.
REQ-012 dp_new_a, dp_new_e  in  32 each  datapath results (T1+T2, d+T1), valid DP_LATENCY cycles after issue.
REQ-013 digest  out  256  final hash; H0 = bits 255:224.
REQ-014 done  out  1  single-cycle pulse marking digest valid.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, FINAL, DONE.
REQ-016 IDLE->ISSUE on accept: load a..h and the chaining register from IV or hash_in, load the 16-word schedule ring from block_in, and set the round counter to 0.
REQ-017 ISSUE SHALL last 1 cycle, then go to WAIT; WAIT SHALL last DP_LATENCY cycles, counted by a latency counter.
REQ-018 dp_a..dp_h, dp_w and dp_select SHALL be stable from ISSUE through the last WAIT cycle of that round.
REQ-019 Capture on the last WAIT edge: h<=g, g<=f, f<=e, e<=dp_new_e, d<=c, c<=b, b<=a, a<=dp_new_a; the ring shifts; the round counter increments.
REQ-020 After capture of round t<63, go to ISSUE; after round 63, go to FINAL.
REQ-021 Schedule words: W[t] = block word t for t<16; for t>=16, W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32.
REQ-022 s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
REQ-023 FINAL: digest word i <= chaining word i + working variable i, mod 2^32, then go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 digest SHALL hold until the next FINAL.
REQ-026 The done pulse SHALL occur 64*(DP_LATENCY+1)+2 edges after the accepting edge; 130 edges for DP_LATENCY=1.
REQ-027 start outside IDLE SHALL be ignored, with no queuing.
REQ-028 Changes on block_in, hash_in or use_iv after accept SHALL have no effect.
REQ-029 dp_new_a and dp_new_e SHALL be ignored except on capture edges.
REQ-030 All additions SHALL be 32-bit and wrap modulo 2^32; no carry is retained.

Reset
REQ-031 rst_n low, at any time including mid-round, SHALL immediately force IDLE.
REQ-032 Reset SHALL clear all counters, the schedule ring, the working variables, the chaining register and digest to 0.
REQ-033 Outputs during reset: ready=1, done=0, dp_* = 0.
REQ-034 The first accept after rst_n deasserts SHALL behave identically to a post-power-up accept.

Structure
REQ-035 A shared package sha256_pkg SHALL hold the IV constants, the state enum, and the s0/s1 and rotate functions.
REQ-036 The schedule ring and its W computation SHALL be the sub-module sha256_msg_sched: load, shift, and w_out ports.
REQ-037 The block SHALL contain no K table; K lookup belongs to the datapath.

Verification
REQ-038 The bench SHALL pair the block with a golden round model of latency DP_LATENCY.
REQ-039 Test "abc": padded block 61626380 00..00 00000018, use_iv=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, done pulse 130 edges after accept.
REQ-040 Test empty message: block 80000000 00..00, use_iv=1 -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-041 Test chaining: feed the "abc" digest as hash_in with use_iv=0 and the same block -> digest matches the golden model; ready stays low throughout the run.
REQ-042 Test DP_LATENCY=3 with "abc" -> same digest; done pulse 258 edges after accept; dp_select is constant across each 4-cycle round.
REQ-043 Test reset at round 30: assert rst_n low -> ready=1 and dp_*=0 immediately; a new "abc" run then gives the correct digest.
REQ-044 Test start held high throughout the run -> exactly one accept per IDLE visit; block_in changes mid-run leave the digest unchanged.
